// File: rtl/lsu_mem_stage.sv
// Memory-access stage: one outstanding valid/ready data-memory request per load/store.
// Define LSU_MISALIGN_CHECK_EN to reject misaligned H/HU/W accesses instead of aligning down.
module lsu_mem_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] pc,
   input  logic [31:0] EX_result,
   input  logic [31:0] rs2_value,
   input  logic [4:0]  rd,
   input  logic        R_wen,
   input  logic [3:0]  csr_wen,
   input  logic [31:0] csrs,
   input  logic        mem_ren,
   input  logic        mem_wen,
   input  logic [2:0]  funct3,
   output logic        stall,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_req_addr,
   output logic        mem_req_wen,
   output logic [31:0] mem_req_wdata,
   output logic [3:0]  mem_req_wstrb,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_rdata,
   output logic [31:0] wb_pc,
   output logic [31:0] wb_data,
   output logic [31:0] wb_csrs,
   output logic [4:0]  wb_rd,
   output logic        wb_R_wen,
   output logic [3:0]  wb_csr_wen,
   output logic        misalign_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state, state_nxt;

   logic [31:0] s_pc, s_addr, s_rs2, s_csrs;
   logic [4:0]  s_rd;
   logic        s_rwen, s_wen;
   logic [3:0]  s_cwen;
   logic [2:0]  s_f3;

   logic        in_mem, in_misal;
   logic [1:0]  off;
   logic [31:0] sh, ld_data, wdata;
   logic [3:0]  wstrb;

   assign in_mem = mem_ren | mem_wen;

`ifdef LSU_MISALIGN_CHECK_EN
   assign in_misal = in_mem &
                     ((funct3[1:0] == 2'b01 & EX_result[0]) |
                      (funct3[1] & (EX_result[1:0] != 2'b00)));
`else
   assign in_misal = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (in_mem & ~in_misal) state_nxt = REQ;
         REQ:     if (mem_req_ready)      state_nxt = RESP;
         RESP:    if (mem_rsp_valid)      state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Rejected accesses lose their write enables here so they retire as bubbles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_pc   <= '0;
         s_addr <= '0;
         s_rs2  <= '0;
         s_csrs <= '0;
         s_rd   <= '0;
         s_rwen <= 1'b0;
         s_wen  <= 1'b0;
         s_cwen <= '0;
         s_f3   <= '0;
      end else if (state == IDLE) begin
         s_pc   <= pc;
         s_addr <= EX_result;
         s_rs2  <= rs2_value;
         s_csrs <= csrs;
         s_rd   <= rd;
         s_rwen <= R_wen & ~in_misal;
         s_wen  <= mem_wen & ~in_misal;
         s_cwen <= csr_wen & {4{~in_misal}};
         s_f3   <= funct3;
      end else if (state == RESP && mem_rsp_valid) begin
         s_rwen <= 1'b0;
         s_wen  <= 1'b0;
         s_cwen <= '0;
      end
   end

   always_comb begin
      off = s_addr[1:0];
      if (s_f3[1])      off = 2'b00;
      else if (s_f3[0]) off[0] = 1'b0;
      wdata = s_rs2;
      wstrb = 4'hF;
      unique case (1'b1)
         s_f3[1]: begin
            wdata = s_rs2;
            wstrb = 4'hF;
         end
         (s_f3[1:0] == 2'b01): begin
            wdata = {2{s_rs2[15:0]}};
            wstrb = 4'b0011 << off;
         end
         (s_f3[1:0] == 2'b00): begin
            wdata = {4{s_rs2[7:0]}};
            wstrb = 4'b0001 << off;
         end
         default: ;
      endcase
   end

   always_comb begin
      sh      = mem_rsp_rdata >> {off, 3'b000};
      ld_data = sh;
      unique case (1'b1)
         s_f3[1]:
            ld_data = sh;
         (s_f3[1:0] == 2'b01):
            ld_data = {{16{sh[15] & ~s_f3[2]}}, sh[15:0]};
         (s_f3[1:0] == 2'b00):
            ld_data = {{24{sh[7] & ~s_f3[2]}}, sh[7:0]};
         default: ;
      endcase
   end

   assign stall         = (state != IDLE);
   assign mem_req_valid = (state == REQ);
   assign mem_req_addr  = mem_req_valid ? {s_addr[31:2], 2'b00} : '0;
   assign mem_req_wen   = mem_req_valid & s_wen;
   assign mem_req_wdata = mem_req_valid ? wdata : '0;
   assign mem_req_wstrb = mem_req_wen ? wstrb : 4'h0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_pc      <= '0;
         wb_data    <= '0;
         wb_csrs    <= '0;
         wb_rd      <= '0;
         wb_R_wen   <= 1'b0;
         wb_csr_wen <= '0;
      end else if (state == IDLE) begin
         wb_pc      <= s_pc;
         wb_data    <= s_addr;
         wb_csrs    <= s_csrs;
         wb_rd      <= s_rd;
         wb_R_wen   <= s_rwen;
         wb_csr_wen <= s_cwen;
      end else if (state == RESP && mem_rsp_valid) begin
         wb_pc      <= s_pc;
         wb_data    <= ld_data;
         wb_csrs    <= s_csrs;
         wb_rd      <= s_rd;
         wb_R_wen   <= s_rwen;
         wb_csr_wen <= s_cwen;
      end else begin
         wb_R_wen   <= 1'b0;
         wb_csr_wen <= '0;
      end
   end

`ifdef LSU_MISALIGN_CHECK_EN
   logic s_misal;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              s_misal <= 1'b0;
      else if (state == IDLE)  s_misal <= in_misal;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) misalign_err <= 1'b0;
      else        misalign_err <= (state == IDLE) & s_misal;
   end
`else
   assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Randomized bench for lsu_mem_stage with a transaction-level write-back model.
// Honours LSU_MISALIGN_CHECK_EN the same way as the design.
module tb_lsu_mem_stage;

   logic        clk, rst_n;
   logic [31:0] pc, EX_result, rs2_value, csrs;
   logic [4:0]  rd;
   logic        R_wen, mem_ren, mem_wen;
   logic [3:0]  csr_wen;
   logic [2:0]  funct3;
   logic        stall, mem_req_valid, mem_req_ready, mem_req_wen;
   logic [31:0] mem_req_addr, mem_req_wdata;
   logic [3:0]  mem_req_wstrb;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_rdata;
   logic [31:0] wb_pc, wb_data, wb_csrs;
   logic [4:0]  wb_rd;
   logic        wb_R_wen;
   logic [3:0]  wb_csr_wen;
   logic        misalign_err;

   lsu_mem_stage dut (
      .clk(clk), .rst_n(rst_n), .pc(pc), .EX_result(EX_result),
      .rs2_value(rs2_value), .rd(rd), .R_wen(R_wen), .csr_wen(csr_wen),
      .csrs(csrs), .mem_ren(mem_ren), .mem_wen(mem_wen), .funct3(funct3),
      .stall(stall), .mem_req_valid(mem_req_valid),
      .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata),
      .mem_req_wstrb(mem_req_wstrb), .mem_rsp_valid(mem_rsp_valid),
      .mem_rsp_rdata(mem_rsp_rdata), .wb_pc(wb_pc), .wb_data(wb_data),
      .wb_csrs(wb_csrs), .wb_rd(wb_rd), .wb_R_wen(wb_R_wen),
      .wb_csr_wen(wb_csr_wen), .misalign_err(misalign_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc, addr, rs2, csrs;
      logic [4:0]  rd;
      logic        rwen;
      logic [3:0]  cwen;
      logic        ren, wen;
      logic [2:0]  f3;
   } ins_t;

   typedef struct packed {
      logic [31:0] pc, data, csrs;
      logic [4:0]  rd;
      logic        rwen;
      logic [3:0]  cwen;
      logic        misal;
   } wb_t;

   int          total = 0;
   int          bad = 0;
   int          stall_cnt = 0;
   int          hs_cnt = 0;
   bit          chk_en = 1'b0;
   wb_t         exp_wb, next_wb;
   logic        exp_misal, exp_stall, exp_valid, exp_wen;
   logic [31:0] exp_addr, exp_wdata;
   logic [3:0]  exp_wstrb;
   logic [31:0] seen_addr, seen_wdata;
   logic [3:0]  seen_wstrb;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         if (bad <= 40)
            $display("FAIL %s: got %h want %h at %0t", nm, act, want, $time);
      end
   endtask

   function automatic int nbytes(input logic [2:0] f3);
      if (f3[1]) return 4;
      if (f3[0]) return 2;
      return 1;
   endfunction

   // Byte offset actually used: the raw offset rounded down to the access size.
   function automatic int offs(input ins_t i);
      int a;
      a = int'(i.addr % 32'd4);
      return a - (a % nbytes(i.f3));
   endfunction

   function automatic logic [3:0] strb_of(input ins_t i);
      int m;
      m = ((1 << nbytes(i.f3)) - 1) << offs(i);
      return 4'(m);
   endfunction

   function automatic logic [31:0] repl_of(input ins_t i);
      case (nbytes(i.f3))
         1:       return (i.rs2 & 32'hFF) * 32'h0101_0101;
         2:       return (i.rs2 & 32'hFFFF) * 32'h0001_0001;
         default: return i.rs2;
      endcase
   endfunction

   function automatic logic [31:0] load_of(input ins_t i, input logic [31:0] rdv);
      logic [31:0] v, mask;
      int nb;
      nb = nbytes(i.f3);
      v  = rdv >> (8 * offs(i));
      if (nb == 4) return v;
      mask = (32'd1 << (8 * nb)) - 32'd1;
      v    = v & mask;
      if (!i.f3[2] && v > (mask >> 1)) v = v | ~mask;
      return v;
   endfunction

   function automatic bit is_misal(input ins_t i);
`ifdef LSU_MISALIGN_CHECK_EN
      return (i.ren || i.wen) && (int'(i.addr % 32'd4) % nbytes(i.f3) != 0);
`else
      return 1'b0;
`endif
   endfunction

   function automatic wb_t mk_wb(input logic [31:0] p, input logic [31:0] d,
                                 input logic [31:0] c, input logic [4:0] r,
                                 input logic rw, input logic [3:0] cw,
                                 input logic m);
      wb_t w;
      w.pc = p; w.data = d; w.csrs = c; w.rd = r;
      w.rwen = rw; w.cwen = cw; w.misal = m;
      return w;
   endfunction

   function automatic ins_t rand_ins();
      ins_t i;
      int k, l;
      i.pc   = $urandom;
      i.addr = $urandom;
      i.rs2  = $urandom;
      i.csrs = $urandom;
      i.rd   = 5'($urandom);
      i.rwen = 1'($urandom);
      i.cwen = 4'($urandom);
      i.ren  = 1'b0;
      i.wen  = 1'b0;
      i.f3   = 3'($urandom);
      k = $urandom_range(0, 2);
      if (k == 1) begin
         l = $urandom_range(0, 4);
         i.ren = 1'b1;
         i.f3  = 3'((l < 3) ? l : l + 1);
      end else if (k == 2) begin
         i.wen = 1'b1;
         i.f3  = 3'($urandom_range(0, 2));
      end
      return i;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bubble();
      exp_wb.rwen = 1'b0;
      exp_wb.cwen = 4'h0;
      exp_misal   = 1'b0;
   endtask

   task automatic load_wb(input wb_t w);
      exp_wb    = w;
      exp_misal = w.misal;
   endtask

   // Presents one instruction in an idle cycle and serves its memory access.
   task automatic issue(input ins_t i, input int d, input int lat,
                        input logic [31:0] rdv, input bit spur);
      bit misal, mem;
      pc = i.pc; EX_result = i.addr; rs2_value = i.rs2; rd = i.rd;
      R_wen = i.rwen; csr_wen = i.cwen; csrs = i.csrs;
      mem_ren = i.ren; mem_wen = i.wen; funct3 = i.f3;
      mem_rsp_valid = spur;
      mem_rsp_rdata = $urandom;
      misal = is_misal(i);
      mem   = (i.ren || i.wen) && !misal;
      tick();
      mem_rsp_valid = 1'b0;
      load_wb(next_wb);
      if (!mem) begin
         next_wb = mk_wb(i.pc, i.addr, i.csrs, i.rd, i.rwen & !misal,
                         misal ? 4'h0 : i.cwen, misal);
         return;
      end
      stall_cnt  = 0;
      hs_cnt     = 0;
      exp_stall  = 1'b1;
      exp_valid  = 1'b1;
      exp_addr   = i.addr & 32'hFFFF_FFFC;
      exp_wen    = i.wen;
      exp_wdata  = repl_of(i);
      exp_wstrb  = i.wen ? strb_of(i) : 4'h0;
      seen_addr  = mem_req_addr;
      seen_wdata = mem_req_wdata;
      seen_wstrb = mem_req_wstrb;
      for (int k = 0; k <= d; k++) begin
         mem_req_ready = (k == d);
         mem_rsp_valid = spur && (k == 0);
         tick();
         bubble();
         mem_rsp_valid = 1'b0;
      end
      mem_req_ready = 1'b0;
      exp_valid     = 1'b0;
      for (int k = 0; k <= lat; k++) begin
         mem_rsp_valid = (k == lat);
         mem_rsp_rdata = (k == lat) ? rdv : $urandom;
         tick();
         if (k < lat) bubble();
      end
      mem_rsp_valid = 1'b0;
      load_wb(mk_wb(i.pc, load_of(i, rdv), i.csrs, i.rd, i.rwen, i.cwen, 1'b0));
      exp_stall = 1'b0;
      next_wb   = mk_wb(i.pc, i.addr, i.csrs, i.rd, 1'b0, 4'h0, 1'b0);
      chk("stall_len", 32'(stall_cnt), 32'(d + lat + 2));
      chk("handshakes", 32'(hs_cnt), 32'd1);
   endtask

   always @(negedge clk) begin
      if (stall) stall_cnt++;
      if (mem_req_valid && mem_req_ready) hs_cnt++;
      if (chk_en) begin
         chk("stall", 32'(stall), 32'(exp_stall));
         chk("req_valid", 32'(mem_req_valid), 32'(exp_valid));
         if (exp_valid) begin
            chk("req_addr", mem_req_addr, exp_addr);
            chk("req_wen", 32'(mem_req_wen), 32'(exp_wen));
            chk("req_wstrb", 32'(mem_req_wstrb), 32'(exp_wstrb));
            if (exp_wen) chk("req_wdata", mem_req_wdata, exp_wdata);
         end
         chk("wb_pc", wb_pc, exp_wb.pc);
         chk("wb_data", wb_data, exp_wb.data);
         chk("wb_csrs", wb_csrs, exp_wb.csrs);
         chk("wb_rd", 32'(wb_rd), 32'(exp_wb.rd));
         chk("wb_R_wen", 32'(wb_R_wen), 32'(exp_wb.rwen));
         chk("wb_csr_wen", 32'(wb_csr_wen), 32'(exp_wb.cwen));
         chk("misalign_err", 32'(misalign_err), 32'(exp_misal));
      end
   end

   initial begin
      ins_t n, a, l, s, w, m;
      rst_n = 1'b1;
      pc = '0; EX_result = '0; rs2_value = '0; rd = '0; R_wen = 1'b0;
      csr_wen = '0; csrs = '0; mem_ren = 1'b0; mem_wen = 1'b0; funct3 = '0;
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
      exp_wb = '0; next_wb = '0; exp_misal = 1'b0; exp_stall = 1'b0;
      exp_valid = 1'b0; exp_wen = 1'b0; exp_addr = '0; exp_wdata = '0;
      exp_wstrb = '0;
      #2 rst_n = 1'b0;
      chk_en = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
      chk("rst_req_addr", mem_req_addr, 32'd0);
      chk("rst_req_wdata", mem_req_wdata, 32'd0);
      chk("rst_req_wstrb", 32'(mem_req_wstrb), 32'd0);
      chk("rst_wb_data", wb_data, 32'd0);
      chk("rst_misalign", 32'(misalign_err), 32'd0);
      rst_n = 1'b1;

      n = '0;
      a = '0; a.pc = 32'h80; a.addr = 32'h1234; a.rd = 5'd5; a.rwen = 1'b1;
      issue(a, 0, 0, '0, 1'b0);
      chk("alu_no_stall", 32'(stall), 32'd0);
      issue(n, 0, 0, '0, 1'b0);
      chk("alu_wb_data", wb_data, 32'h1234);
      chk("alu_wb_rd", 32'(wb_rd), 32'd5);
      chk("alu_wb_rwen", 32'(wb_R_wen), 32'd1);

      l = '0; l.addr = 32'h103; l.ren = 1'b1; l.f3 = 3'b000;
      l.rd = 5'd7; l.rwen = 1'b1;
      issue(l, 0, 2, 32'h80FF_0000, 1'b0);
      chk("lb_req_addr", seen_addr, 32'h100);
      chk("lb_wstrb", 32'(seen_wstrb), 32'd0);
      chk("lb_wb_data", wb_data, 32'hFFFF_FF80);
      chk("lb_stall_cycles", 32'(stall_cnt), 32'd4);

      s = '0; s.addr = 32'h206; s.wen = 1'b1; s.f3 = 3'b001;
      s.rs2 = 32'hABCD_1234;
      issue(s, 0, 1, 32'h5555_AAAA, 1'b0);
      chk("sh_wdata", seen_wdata, 32'h1234_1234);
      chk("sh_wstrb", 32'(seen_wstrb), 32'hC);
      chk("sh_wb_rwen", 32'(wb_R_wen), 32'd0);

      w = '0; w.addr = 32'h40C; w.ren = 1'b1; w.f3 = 3'b010; w.rwen = 1'b1;
      issue(w, 3, 1, 32'h0BAD_F00D, 1'b0);
      chk("slow_handshakes", 32'(hs_cnt), 32'd1);
      chk("slow_stall_cycles", 32'(stall_cnt), 32'd6);

      m = '0; m.pc = 32'h44; m.addr = 32'h302; m.ren = 1'b1; m.f3 = 3'b010;
      m.rd = 5'd9; m.rwen = 1'b1;
`ifdef LSU_MISALIGN_CHECK_EN
      issue(m, 0, 0, '0, 1'b0);
      chk("mis_no_stall", 32'(stall), 32'd0);
      chk("mis_no_req", 32'(mem_req_valid), 32'd0);
      issue(n, 0, 0, '0, 1'b0);
      chk("mis_pulse", 32'(misalign_err), 32'd1);
      chk("mis_wb_rwen", 32'(wb_R_wen), 32'd0);
      issue(n, 0, 0, '0, 1'b0);
      chk("mis_pulse_end", 32'(misalign_err), 32'd0);
`else
      issue(m, 0, 1, 32'hDEAD_BEEF, 1'b0);
      chk("lw_req_addr", seen_addr, 32'h300);
      chk("lw_wb_data", wb_data, 32'hDEAD_BEEF);
      chk("lw_wb_rwen", 32'(wb_R_wen), 32'd1);
`endif

      // Abort a load while it waits for its response.
      w.addr = 32'h400;
      pc = w.pc; EX_result = w.addr; rs2_value = w.rs2; rd = w.rd;
      R_wen = w.rwen; csr_wen = w.cwen; csrs = w.csrs;
      mem_ren = w.ren; mem_wen = w.wen; funct3 = w.f3;
      tick();
      load_wb(next_wb);
      exp_stall = 1'b1; exp_valid = 1'b1; exp_addr = 32'h400;
      exp_wen = 1'b0; exp_wstrb = 4'h0;
      mem_req_ready = 1'b1;
      tick();
      bubble();
      mem_req_ready = 1'b0;
      exp_valid = 1'b0;
      tick();
      bubble();
      #1;
      rst_n = 1'b0;
      pc = '0; EX_result = '0; rs2_value = '0; rd = '0; R_wen = 1'b0;
      csr_wen = '0; csrs = '0; mem_ren = 1'b0; mem_wen = 1'b0; funct3 = '0;
      exp_wb = '0; exp_misal = 1'b0; exp_stall = 1'b0; exp_valid = 1'b0;
      next_wb = '0;
      @(posedge clk);
      #1;
      chk("abort_stall", 32'(stall), 32'd0);
      chk("abort_req_valid", 32'(mem_req_valid), 32'd0);
      rst_n = 1'b1;
      issue(n, 0, 0, '0, 1'b1);
      chk("late_rsp_stall", 32'(stall), 32'd0);
      chk("late_rsp_wb_data", wb_data, 32'd0);
      chk("late_rsp_wb_rwen", 32'(wb_R_wen), 32'd0);

      repeat (300)
         issue(rand_ins(), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom, ($urandom % 4) == 0);
      issue(n, 0, 0, '0, 1'b0);
      issue(n, 0, 0, '0, 1'b0);
      @(negedge clk);
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
